// File: rtl/sp_arbiter.sv
// Round-robin arbiter feeding fixed-length jobs from two requesters into a
// shared signal processor and routing its results back with an owner tag.
module sp_arbiter #(
  parameter int unsigned JOB_LEN = 32'd6,
  parameter int unsigned RES_LEN = 32'd3,
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_cg_en,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [8:0] a_data,
  input  logic [8:0] b_data,
  input  logic [2:0] a_mode,
  input  logic [2:0] b_mode,
  output logic       rd_a,
  output logic       rd_b,
  output logic       sp_in_valid,
  output logic [8:0] sp_in_data,
  output logic [2:0] sp_in_mode,
  output logic       sp_cg_en,
  input  logic       sp_out_valid,
  input  logic [8:0] sp_out_data,
  output logic       rsp_valid,
  output logic [8:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_last,
  output logic       busy,
  output logic       err_timeout
);

  localparam int FW = $clog2(JOB_LEN + 32'd1);
  localparam int RW = $clog2(RES_LEN + 32'd1);
  localparam int TW = $clog2(TIMEOUT + 32'd1);
  localparam logic [FW-1:0] FEED_LAST = FW'(JOB_LEN - 32'd1);
  localparam logic [RW-1:0] RES_LAST  = RW'(RES_LEN - 32'd1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FEED    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_COLLECT = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          owner_r, owner_s;
  logic          prio_b_r, prio_b_s;
  logic [FW-1:0] feed_cnt_r, feed_cnt_s;
  logic [RW-1:0] res_cnt_r, res_cnt_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;

  logic       rd_a_r, rd_a_s, rd_b_r, rd_b_s;
  logic       sp_in_valid_r, sp_in_valid_s;
  logic [8:0] sp_in_data_r, sp_in_data_s;
  logic [2:0] sp_in_mode_r, sp_in_mode_s;
  logic       sp_cg_en_r, sp_cg_en_s;
  logic       rsp_valid_r, rsp_valid_s;
  logic [8:0] rsp_data_r, rsp_data_s;
  logic       rsp_id_r, rsp_id_s;
  logic       rsp_last_r, rsp_last_s;
  logic       busy_r, busy_s;
  logic       err_timeout_r, err_timeout_s;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_s       = state_r;
    owner_s       = owner_r;
    prio_b_s      = prio_b_r;
    feed_cnt_s    = feed_cnt_r;
    res_cnt_s     = res_cnt_r;
    to_cnt_s      = to_cnt_r;
    sp_in_valid_s = 1'b0;
    sp_in_data_s  = 9'd0;
    sp_in_mode_s  = 3'd0;
    rsp_valid_s   = 1'b0;
    rsp_data_s    = 9'd0;
    rsp_id_s      = 1'b0;
    rsp_last_s    = 1'b0;
    err_timeout_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        feed_cnt_s = '0;
        res_cnt_s  = '0;
        to_cnt_s   = '0;
        if (req_a || req_b) begin
          state_s  = ST_FEED;
          owner_s  = (req_a && req_b) ? prio_b_r : req_b;
          prio_b_s = ~owner_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FEED: begin
        sp_in_valid_s = 1'b1;
        sp_in_data_s  = owner_r ? b_data : a_data;
        if (feed_cnt_r == '0) begin
          sp_in_mode_s = owner_r ? b_mode : a_mode;
        end else begin
          sp_in_mode_s = 3'd0;
        end
        if (feed_cnt_r == FEED_LAST) begin
          state_s    = ST_WAIT;
          feed_cnt_s = '0;
          to_cnt_s   = '0;
        end else begin
          feed_cnt_s = feed_cnt_r + FW'(1);
        end
      end
      ST_WAIT, ST_COLLECT: begin
        // The cycle showing rsp_last is the final COLLECT cycle of the job.
        if (rsp_last_r) begin
          state_s   = ST_IDLE;
          res_cnt_s = '0;
          to_cnt_s  = '0;
        end else if (sp_out_valid) begin
          state_s     = ST_COLLECT;
          rsp_valid_s = 1'b1;
          rsp_data_s  = sp_out_data;
          rsp_id_s    = owner_r;
          to_cnt_s    = '0;
          if (res_cnt_r == RES_LAST) begin
            rsp_last_s = 1'b1;
          end else begin
            res_cnt_s = res_cnt_r + RW'(1);
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_s       = ST_IDLE;
          err_timeout_s = 1'b1;
          to_cnt_s      = '0;
          res_cnt_s     = '0;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    rd_a_s     = (state_s == ST_FEED) && !owner_s;
    rd_b_s     = (state_s == ST_FEED) && owner_s;
    busy_s     = (state_s != ST_IDLE);
    sp_cg_en_s = (state_s == ST_FEED) ? 1'b0 : cfg_cg_en;
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      owner_r       <= 1'b0;
      prio_b_r      <= 1'b0;
      feed_cnt_r    <= '0;
      res_cnt_r     <= '0;
      to_cnt_r      <= '0;
      rd_a_r        <= 1'b0;
      rd_b_r        <= 1'b0;
      sp_in_valid_r <= 1'b0;
      sp_in_data_r  <= 9'd0;
      sp_in_mode_r  <= 3'd0;
      sp_cg_en_r    <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 9'd0;
      rsp_id_r      <= 1'b0;
      rsp_last_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      owner_r       <= owner_s;
      prio_b_r      <= prio_b_s;
      feed_cnt_r    <= feed_cnt_s;
      res_cnt_r     <= res_cnt_s;
      to_cnt_r      <= to_cnt_s;
      rd_a_r        <= rd_a_s;
      rd_b_r        <= rd_b_s;
      sp_in_valid_r <= sp_in_valid_s;
      sp_in_data_r  <= sp_in_data_s;
      sp_in_mode_r  <= sp_in_mode_s;
      sp_cg_en_r    <= sp_cg_en_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_data_r    <= rsp_data_s;
      rsp_id_r      <= rsp_id_s;
      rsp_last_r    <= rsp_last_s;
      busy_r        <= busy_s;
      err_timeout_r <= err_timeout_s;
    end
  end

  assign rd_a        = rd_a_r;
  assign rd_b        = rd_b_r;
  assign sp_in_valid = sp_in_valid_r;
  assign sp_in_data  = sp_in_data_r;
  assign sp_in_mode  = sp_in_mode_r;
  assign sp_cg_en    = sp_cg_en_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_id      = rsp_id_r;
  assign rsp_last    = rsp_last_r;
  assign busy        = busy_r;
  assign err_timeout = err_timeout_r;

endmodule
